// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI readback path
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/p2s_shift_register.sv
// rtl/p2s_shift_register.sv - 8-bit parallel-to-serial shifter, MSB first, negedge sclk
//   sclk       in   SPI clock, state updates on negedge
//   rstn       in   asynchronous active-low reset
//   load       in   capture d (takes priority over shift)
//   shift      in   shift left by one, zero fill
//   d          in   parallel byte
//   serial_out out  q[7]
module p2s_shift_register
  import spi_pkg::*;
(
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  shift,
  input  logic [SPI_BYTE_W-1:0] d,
  output logic                  serial_out
);

  logic [SPI_BYTE_W-1:0] q_q;
  logic [SPI_BYTE_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shift) begin
      q_d = {q_q[SPI_BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(negedge sclk or negedge rstn) begin
    if (!rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign serial_out = q_q[SPI_BYTE_W-1];

endmodule

// File: rtl/spi_readback_serializer.sv
// rtl/spi_readback_serializer.sv - SPI MISO readback serializer with auto-incrementing pointer
//   sclk       in   SPI clock, state updates on negedge
//   rstn       in   asynchronous active-low (frame-stop) reset
//   tx_en      in   read mode active
//   addr_load  in   start-address strobe from the command decoder
//   start_addr in   first register address
//   rd_data    in   register-bank mux output for rd_addr
//   rd_addr    out  address presented to the register-bank mux
//   miso       out  serial data, MSB first
//   busy       out  high in LOAD or SHIFT
//   byte_done  out  one-period pulse per completed byte
//   addr_ovf   out  sticky, read attempted past the last register (WRAP=0)
module spi_readback_serializer
  import spi_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int WRAP     = 0
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  tx_en,
  input  logic                  addr_load,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [SPI_BYTE_W-1:0] rd_data,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  miso,
  output logic                  busy,
  output logic                  byte_done,
  output logic                  addr_ovf
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  tx_state_t             state_q, state_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  zero_fill_q, zero_fill_d;
  logic                  addr_ovf_q, addr_ovf_d;
  logic                  byte_done_q, byte_done_d;
  logic                  sr_load;
  logic                  sr_shift;
  logic [SPI_BYTE_W-1:0] sr_d;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    bit_cnt_d   = bit_cnt_q;
    zero_fill_d = zero_fill_q;
    addr_ovf_d  = addr_ovf_q;
    byte_done_d = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_d        = '0;

    case (state_q)
      IDLE: begin
        if (tx_en && addr_load) begin
          rd_addr_d   = start_addr;
          zero_fill_d = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        sr_load = 1'b1;
        if (!tx_en) begin
          state_d = IDLE;
        end else begin
          sr_d      = zero_fill_q ? '0 : rd_data;
          bit_cnt_d = 3'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!tx_en) begin
          // Discard the partial byte; clearing the shifter forces miso low.
          sr_load   = 1'b1;
          bit_cnt_d = 3'd0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          // Advance the pointer one period early so the mux has settled
          // by the time the next byte is captured.
          if (bit_cnt_q == 3'd6) begin
            if (rd_addr_q < LAST_ADDR) begin
              rd_addr_d = rd_addr_q + 1'b1;
            end else if (WRAP != 0) begin
              rd_addr_d = '0;
            end else begin
              zero_fill_d = 1'b1;
              addr_ovf_d  = 1'b1;
            end
          end
          if (bit_cnt_q == 3'd7) begin
            sr_load     = 1'b1;
            sr_d        = zero_fill_q ? '0 : rd_data;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b1;
          end else begin
            sr_shift = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(negedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      bit_cnt_q   <= 3'd0;
      zero_fill_q <= 1'b0;
      addr_ovf_q  <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      bit_cnt_q   <= bit_cnt_d;
      zero_fill_q <= zero_fill_d;
      addr_ovf_q  <= addr_ovf_d;
      byte_done_q <= byte_done_d;
    end
  end

  p2s_shift_register u_p2s (
    .sclk       (sclk),
    .rstn       (rstn),
    .load       (sr_load),
    .shift      (sr_shift),
    .d          (sr_d),
    .serial_out (miso)
  );

  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q != IDLE);
  assign byte_done = byte_done_q;
  assign addr_ovf  = addr_ovf_q;

endmodule

// File: tb/tb_spi_readback_serializer.sv
// tb/tb_spi_readback_serializer.sv - directed self-checking bench for spi_readback_serializer
`timescale 1ns/1ps
module tb_spi_readback_serializer;

  logic       sclk;
  logic       rstn;
  logic       tx_en;
  logic       addr_load;
  logic [7:0] start_addr;
  logic [7:0] rd_data0, rd_data1;
  logic [7:0] rd_addr0, rd_addr1;
  logic       miso0, miso1;
  logic       busy0, busy1;
  logic       byte_done0, byte_done1;
  logic       addr_ovf0, addr_ovf1;

  logic [7:0] regs [16];

  int checks   = 0;
  int failures = 0;

  assign rd_data0 = regs[rd_addr0[3:0]];
  assign rd_data1 = regs[rd_addr1[3:0]];

  spi_readback_serializer #(.ADDR_W(8), .NUM_REGS(16), .WRAP(0)) dut0 (
    .sclk(sclk), .rstn(rstn), .tx_en(tx_en), .addr_load(addr_load),
    .start_addr(start_addr), .rd_data(rd_data0), .rd_addr(rd_addr0),
    .miso(miso0), .busy(busy0), .byte_done(byte_done0), .addr_ovf(addr_ovf0)
  );

  spi_readback_serializer #(.ADDR_W(8), .NUM_REGS(16), .WRAP(1)) dut1 (
    .sclk(sclk), .rstn(rstn), .tx_en(tx_en), .addr_load(addr_load),
    .start_addr(start_addr), .rd_data(rd_data1), .rd_addr(rd_addr1),
    .miso(miso1), .busy(busy1), .byte_done(byte_done1), .addr_ovf(addr_ovf1)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance across one negedge; return 1 ns after the following posedge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sclk);
      #1;
    end
  endtask

  // addr_load is sampled at the first negedge crossed here (negedge N).
  task automatic start(input logic [7:0] a);
    tx_en      = 1'b1;
    addr_load  = 1'b1;
    start_addr = a;
    step(1);
    addr_load  = 1'b0;
  endtask

  task automatic do_reset();
    tx_en     = 1'b0;
    addr_load = 1'b0;
    rstn      = 1'b0;
    step(2);
    rstn      = 1'b1;
  endtask

  logic [23:0] bits;
  int          dones;

  initial begin
    rstn       = 1'b0;
    tx_en      = 1'b0;
    addr_load  = 1'b0;
    start_addr = 8'd0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    step(2);

    // Reset values
    chk("rst_miso",      32'(miso0),      32'h0);
    chk("rst_busy",      32'(busy0),      32'h0);
    chk("rst_byte_done", 32'(byte_done0), 32'h0);
    chk("rst_addr_ovf",  32'(addr_ovf0),  32'h0);
    chk("rst_rd_addr",   32'(rd_addr0),   32'h0);
    rstn = 1'b1;
    step(1);

    // Single byte 0xA5 from address 3, followed by MSB of reg4 = 0x80
    regs[3] = 8'hA5;
    regs[4] = 8'h80;
    start(8'd3);
    chk("single_load_busy", 32'(busy0), 32'h1);
    chk("single_load_miso", 32'(miso0), 32'h0);
    bits  = '0;
    dones = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      bits  = {bits[22:0], miso0};
      dones = dones + 32'(byte_done0);
    end
    chk("single_byte",        32'(bits[7:0]), 32'hA5);
    chk("single_no_early_bd", 32'(dones),     32'h0);
    step(1);
    chk("single_byte_done",   32'(byte_done0), 32'h1);
    chk("single_next_msb",    32'(miso0),      32'h1);
    tx_en = 1'b0;
    step(1);
    chk("single_stop_busy", 32'(busy0), 32'h0);
    chk("single_stop_miso", 32'(miso0), 32'h0);
    chk("single_stop_bd",   32'(byte_done0), 32'h0);

    // Burst 0x11 0x22 0x33 from address 0
    do_reset();
    regs[0] = 8'h11;
    regs[1] = 8'h22;
    regs[2] = 8'h33;
    start(8'd0);
    bits  = '0;
    dones = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      if (k <= 24) bits = {bits[22:0], miso0};
      dones = dones + 32'(byte_done0);
      if (k == 7)  chk("burst_addr_k7",  32'(rd_addr0), 32'h0);
      if (k == 8)  chk("burst_addr_k8",  32'(rd_addr0), 32'h1);
      if (k == 16) chk("burst_addr_k16", 32'(rd_addr0), 32'h2);
    end
    chk("burst_stream", 32'(bits), 32'h112233);
    chk("burst_dones",  32'(dones), 32'h3);
    tx_en = 1'b0;
    step(1);

    // End of map from address 15: WRAP=0 zero-fills, WRAP=1 wraps to reg0
    do_reset();
    regs[15] = 8'hC3;
    start(8'd15);
    bits = '0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      bits = {bits[22:0], 1'b0};
      bits[0]  = miso0;
      bits[23] = 1'b0;
      if (k == 8) chk("eom_ovf_set", 32'(addr_ovf0), 32'h1);
    end
    chk("eom_nowrap_stream", 32'(bits[15:0]), 32'hC300);
    chk("eom_nowrap_addr",   32'(rd_addr0),   32'hF);
    chk("eom_nowrap_ovf",    32'(addr_ovf0),  32'h1);
    tx_en = 1'b0;
    step(1);
    chk("eom_ovf_sticky", 32'(addr_ovf0), 32'h1);

    do_reset();
    start(8'd15);
    bits = '0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      bits = {bits[22:0], miso1};
    end
    chk("eom_wrap_stream", 32'(bits[15:0]), 32'hC311);
    chk("eom_wrap_addr",   32'(rd_addr1),   32'h1);
    chk("eom_wrap_ovf",    32'(addr_ovf1),  32'h0);
    tx_en = 1'b0;
    step(1);

    // Abort after four bits of 0xF0
    do_reset();
    chk("abort_ovf_cleared", 32'(addr_ovf0), 32'h0);
    regs[6] = 8'hF0;
    start(8'd6);
    bits = '0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      bits = {bits[22:0], miso0};
    end
    chk("abort_first_bits", 32'(bits[3:0]), 32'hF);
    tx_en = 1'b0;
    step(1);
    chk("abort_miso", 32'(miso0), 32'h0);
    chk("abort_busy", 32'(busy0), 32'h0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      dones = dones + 32'(byte_done0);
      step(1);
    end
    chk("abort_no_byte_done", 32'(dones), 32'h0);

    // Asynchronous reset mid-byte, then a fresh load of reg5
    regs[7] = 8'hFF;
    regs[5] = 8'h5A;
    start(8'd7);
    step(3);
    chk("mrst_pre_miso", 32'(miso0), 32'h1);
    rstn = 1'b0;
    #1;
    chk("mrst_miso",    32'(miso0),      32'h0);
    chk("mrst_busy",    32'(busy0),      32'h0);
    chk("mrst_rd_addr", 32'(rd_addr0),   32'h0);
    chk("mrst_bd",      32'(byte_done0), 32'h0);
    step(1);
    rstn = 1'b1;
    start(8'd5);
    bits = '0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      bits = {bits[22:0], miso0};
    end
    chk("mrst_reload_byte", 32'(bits[7:0]), 32'h5A);
    tx_en = 1'b0;
    step(1);

    // addr_load during SHIFT is ignored
    do_reset();
    regs[2] = 8'h3C;
    regs[3] = 8'hC5;
    regs[9] = 8'h99;
    start(8'd2);
    bits = '0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      addr_load  = (k == 3);
      start_addr = 8'd9;
      bits = {bits[22:0], miso0};
    end
    chk("reload_stream", 32'(bits[15:0]), 32'h3CC5);
    chk("reload_addr",   32'(rd_addr0),   32'h4);
    tx_en = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
